// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// Holds the FSM state, the recoded Booth operation and the counter sizing function.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD1 = 3'd1,
    OP_SUB1 = 3'd2,
    OP_ADD2 = 3'd3,
    OP_SUB2 = 3'd4
  } booth_op_t;

  // Counter width: must be able to hold STEPS, which is at most WIDTH.
  function automatic int steps(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic booth_op_t recode2(input logic [1:0] win);
    case (win)
      2'b01:   return OP_ADD1;
      2'b10:   return OP_SUB1;
      default: return OP_NOP;
    endcase
  endfunction

  function automatic booth_op_t recode4(input logic [2:0] win);
    case (win)
      3'b001, 3'b010: return OP_ADD1;
      3'b011:         return OP_ADD2;
      3'b100:         return OP_SUB2;
      3'b101, 3'b110: return OP_SUB1;
      default:        return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// Parametrised adder/subtractor: sum = a + b when sub=0, a - b when sub=1.
// Subtraction is b inverted with a carry-in of one.
module booth_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  logic [N-1:0] b_x;

  assign b_x = b ^ {N{sub}};
  assign sum = a + b_x + {{(N-1){1'b0}}, sub};

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative signed Booth multiplier, one recoding step per clock, start/busy/done handshake.
// Define BOOTH_RADIX4_EN for the radix-4 (modified Booth) datapath; default is radix-2.
module booth_seq_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

`ifdef BOOTH_RADIX4_EN
  localparam int STEPS = WIDTH / 2;
  localparam int AW    = WIDTH + 2;
`else
  localparam int STEPS = WIDTH;
  localparam int AW    = WIDTH + 1;
`endif
  localparam int CW = steps(WIDTH);

  state_t             state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  booth_op_t          op;
  logic [AW-1:0]      m_ext, addend, sum, acc_sh;
  logic [WIDTH-1:0]   q_sh;
  logic               qm1_sh, sub;

  // Guard bits in the accumulator keep -2^(WIDTH-1) (and its double) representable.
  assign m_ext = {{(AW-WIDTH){m_q[WIDTH-1]}}, m_q};

`ifdef BOOTH_RADIX4_EN
  assign op     = recode4({q_q[1:0], qm1_q});
  assign acc_sh = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign q_sh   = {sum[1:0], q_q[WIDTH-1:2]};
  assign qm1_sh = q_q[1];
`else
  assign op     = recode2({q_q[0], qm1_q});
  assign acc_sh = {sum[AW-1], sum[AW-1:1]};
  assign q_sh   = {sum[0], q_q[WIDTH-1:1]};
  assign qm1_sh = q_q[0];
`endif

  always_comb begin
    addend = '0;
    sub    = 1'b0;
    case (op)
      OP_ADD1: addend = m_ext;
      OP_SUB1: begin addend = m_ext; sub = 1'b1; end
`ifdef BOOTH_RADIX4_EN
      OP_ADD2: addend = {m_ext[AW-2:0], 1'b0};
      OP_SUB2: begin addend = {m_ext[AW-2:0], 1'b0}; sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  booth_addsub #(.N(AW)) u_addsub (
    .a   (acc_q),
    .b   (addend),
    .sub (sub),
    .sum (sum)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          acc_d   = '0;
          q_d     = multiplier;
          qm1_d   = 1'b0;
          m_d     = multiplicand;
          count_d = CW'(STEPS);
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d   = acc_sh;
        q_d     = q_sh;
        qm1_d   = qm1_sh;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d   = DONE;
          product_d = {acc_sh[WIDTH-1:0], q_sh};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier (WIDTH=8), radix-2 or radix-4 via BOOTH_RADIX4_EN.
// Driver pushes expected products; a negedge monitor pops and compares on every done pulse.
module tb_booth_seq_multiplier;
  import booth_pkg::*;

  localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
  localparam int STEPS = W / 2;
`else
  localparam int STEPS = W;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   mcand, mplier;
  logic           busy, done;
  logic [2*W-1:0] product;

  logic [2*W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got product %h with no expectation queued", product);
      end else begin
        check("product", 32'(product), 32'(exp_q.pop_front()));
      end
    end
  end

  // One operation; optional re-pulse of start with junk operands mid-RUN.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] e, input bit glitch);
    int edges;
    int busy_cyc;
    exp_q.push_back(e);
    mcand = a;
    mplier = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    busy_cyc = 0;
    while (!done && edges < 64) begin
      if (busy) busy_cyc++;
      if (glitch && edges == 2) begin
        start  = 1'b1;
        mcand  = W'($urandom_range(0, 255));
        mplier = W'($urandom_range(0, 255));
      end else begin
        start = 1'b0;
      end
      tick();
      edges++;
    end
    start = 1'b0;
    check("latency", 32'(edges), 32'(STEPS + 1));
    check("busy_cycles", 32'(busy_cyc), 32'(STEPS));
    tick();
    check("done_pulse", 32'(done), 32'(0));
  endtask

  initial begin
    int edges;
    logic [W-1:0] ra, rb;
    logic signed [2*W-1:0] rp;

    rst = 1'b1;
    start = 1'b0;
    mcand = '0;
    mplier = '0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_product", 32'(product), 32'(0));
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    tick();

    run_op(8'd7,   8'hFD, 16'hFFEB, 1'b0);
    run_op(8'h80,  8'h80, 16'h4000, 1'b0);
    run_op(8'h7F,  8'h80, 16'hC080, 1'b0);
    run_op(8'd0,   8'h55, 16'h0000, 1'b0);
    run_op(8'd7,   8'hFD, 16'hFFEB, 1'b1);
    run_op(8'h80,  8'h01, 16'hFF80, 1'b0);
    run_op(8'h7F,  8'h7F, 16'h3F01, 1'b0);

    // Abort on the 4th RUN edge (edge 5 counting the accept edge as 1).
    mcand = 8'h55;
    mplier = 8'h33;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_product", 32'(product), 32'(0));
    run_op(8'hFB, 8'd9, 16'hFFD3, 1'b0);

    // start held high through DONE: back-to-back operations.
    mcand = 8'd5;
    mplier = 8'd5;
    exp_q.push_back(16'h0019);
    start = 1'b1;
    tick();
    edges = 1;
    while (!done && edges < 64) begin
      tick();
      edges++;
    end
    check("b2b_latency1", 32'(edges), 32'(STEPS + 1));
    mcand = 8'd3;
    mplier = 8'hFE;
    exp_q.push_back(16'hFFFA);
    tick();
    check("b2b_busy", 32'(busy), 32'(1));
    start = 1'b0;
    edges = 1;
    while (!done && edges < 64) begin
      tick();
      edges++;
    end
    check("b2b_latency2", 32'(edges), 32'(STEPS + 1));
    tick();
    check("b2b_done_pulse", 32'(done), 32'(0));

    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rp = $signed(ra) * $signed(rb);
      run_op(ra, rb, rp, 1'b0);
    end

    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
